// File: rtl/game_frame_controller.sv
// game_frame_controller: per-frame sequencer for the dino runner (dino jump, obstacle scroll, score, modes)
module game_frame_controller #(
    parameter int DINO_X          = 100,
    parameter int GROUND_Y        = 320,
    parameter int JUMP_HEIGHT     = 120,
    parameter int JUMP_STEP       = 6,
    parameter int OBST_START_X    = 680,
    parameter int OBST_SPEED_INIT = 4,
    parameter int OBST_SPEED_MAX  = 12,
    parameter int SPEEDUP_EVERY   = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        screen_ready,
    input  logic        collision_detected,
    input  logic        jump_btn,
    input  logic        pause_btn,
    output logic [31:0] x_coor,
    output logic [31:0] y_coor,
    output logic [31:0] x_coor_obstacle,
    output logic [31:0] y_coor_obstacle,
    output logic        game_over,
    output logic        pause,
    output logic [15:0] score
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSED, OVER} state_t;
    typedef enum logic [1:0] {GROUND, RISING, FALLING} phase_t;

    localparam logic [11:0] G_Y   = 12'(GROUND_Y);
    localparam logic [11:0] APEX  = 12'(GROUND_Y - JUMP_HEIGHT);
    localparam logic [11:0] STEP  = 12'(JUMP_STEP);
    localparam logic [11:0] O_X   = 12'(OBST_START_X);
    localparam logic [11:0] SP_I  = 12'(OBST_SPEED_INIT);
    localparam logic [11:0] SP_M  = 12'(OBST_SPEED_MAX);
    localparam logic [7:0]  SP_EV = 8'(SPEEDUP_EVERY);

    state_t      state_q, state_d;
    phase_t      phase_q, phase_d;
    logic [11:0] y_q, y_d, xo_q, xo_d, speed_q, speed_d, ny;
    logic [15:0] score_q, score_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [2:0]  jsync_q, jsync_d, psync_q, psync_d;
    logic        sr_q, sr_d, jreq_q, jreq_d, preq_q, preq_d;
    logic        go_q, go_d, pa_q, pa_d, tick, move;

    assign tick            = screen_ready & ~sr_q;
    assign x_coor          = 32'(DINO_X);
    assign y_coor          = {20'd0, y_q};
    assign x_coor_obstacle = {20'd0, xo_q};
    assign y_coor_obstacle = 32'(GROUND_Y);
    assign game_over       = go_q;
    assign pause           = pa_q;
    assign score           = score_q;

    // Next-state: button sync/edge capture, then one game step per frame tick
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        y_d     = y_q;
        xo_d    = xo_q;
        speed_d = speed_q;
        score_d = score_q;
        cnt_d   = cnt_q;
        ny      = y_q;
        move    = 1'b0;
        sr_d    = screen_ready;
        jsync_d = {jsync_q[1:0], jump_btn};
        psync_d = {psync_q[1:0], pause_btn};
        jreq_d  = tick ? 1'b0 : (jreq_q | (jsync_q[1] & ~jsync_q[2]));
        preq_d  = tick ? 1'b0 : (preq_q | (psync_q[1] & ~psync_q[2]));
        if (tick) begin
            case (state_q)
                IDLE:    if (jreq_q) begin state_d = RUN; move = 1'b1; end
                RUN:     if (collision_detected) state_d = OVER;
                         else if (preq_q) state_d = PAUSED;
                         else move = 1'b1;
                PAUSED:  if (preq_q) state_d = RUN;
                default: if (jreq_q) begin
                             state_d = RUN;
                             phase_d = GROUND;
                             y_d     = G_Y;
                             xo_d    = O_X;
                             speed_d = SP_I;
                             score_d = '0;
                             cnt_d   = '0;
                         end
            endcase
        end
        if (move) begin
            case (phase_q)
                GROUND:  if (jreq_q) begin y_d = y_q - STEP; phase_d = RISING; end
                RISING:  begin
                             ny      = y_q - STEP;
                             y_d     = (ny <= APEX) ? APEX : ny;
                             phase_d = (ny <= APEX) ? FALLING : RISING;
                         end
                default: begin
                             ny      = y_q + STEP;
                             y_d     = (ny >= G_Y) ? G_Y : ny;
                             phase_d = (ny >= G_Y) ? GROUND : FALLING;
                         end
            endcase
            if (xo_q <= speed_q) begin
                xo_d    = O_X;
                score_d = (score_q == 16'hFFFF) ? score_q : score_q + 16'd1;
                cnt_d   = (cnt_q + 8'd1 == SP_EV) ? 8'd0 : cnt_q + 8'd1;
                speed_d = (cnt_q + 8'd1 != SP_EV) ? speed_q :
                          (speed_q >= SP_M) ? SP_M : speed_q + 12'd1;
            end else begin
                xo_d = xo_q - speed_q;
            end
        end
        go_d = (state_d == OVER);
        pa_d = (state_d == PAUSED);
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            phase_q <= GROUND;
            y_q     <= G_Y;
            xo_q    <= O_X;
            speed_q <= SP_I;
            score_q <= '0;
            cnt_q   <= '0;
            sr_q    <= 1'b0;
            jsync_q <= '0;
            psync_q <= '0;
            jreq_q  <= 1'b0;
            preq_q  <= 1'b0;
            go_q    <= 1'b0;
            pa_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            y_q     <= y_d;
            xo_q    <= xo_d;
            speed_q <= speed_d;
            score_q <= score_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            jsync_q <= jsync_d;
            psync_q <= psync_d;
            jreq_q  <= jreq_d;
            preq_q  <= preq_d;
            go_q    <= go_d;
            pa_q    <= pa_d;
        end
    end
endmodule

// File: tb/tb_game_frame_controller.sv
// tb_game_frame_controller: directed table plus hand sequences for game_frame_controller
module tb_game_frame_controller;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        screen_ready = 1'b0;
    logic        collision_detected = 1'b0;
    logic        jump_btn = 1'b0;
    logic        pause_btn = 1'b0;
    logic [31:0] x_coor, y_coor, x_coor_obstacle, y_coor_obstacle;
    logic        game_over, pause;
    logic [15:0] score;
    int          passed = 0;
    int          total = 0;

    typedef struct {
        logic        jump;
        logic        pse;
        logic        coll;
        logic [31:0] y;
        logic [31:0] xo;
        logic        go;
        logic        pa;
        logic [15:0] sc;
    } vec_t;

    vec_t vecs[9];

    game_frame_controller dut (
        .clk(clk), .reset(reset), .screen_ready(screen_ready),
        .collision_detected(collision_detected), .jump_btn(jump_btn), .pause_btn(pause_btn),
        .x_coor(x_coor), .y_coor(y_coor), .x_coor_obstacle(x_coor_obstacle),
        .y_coor_obstacle(y_coor_obstacle), .game_over(game_over), .pause(pause), .score(score)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic frame();
        @(negedge clk) screen_ready = 1'b1;
        repeat (4) @(negedge clk);
        screen_ready = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame();
    endtask

    task automatic press(input logic j, input logic p);
        @(negedge clk);
        jump_btn = j;
        pause_btn = p;
        repeat (2) @(negedge clk);
        jump_btn = 1'b0;
        pause_btn = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic chk_all(input string tag, input logic [31:0] y, input logic [31:0] xo,
                           input logic go, input logic pa, input logic [15:0] sc);
        chk({tag, ".y"}, y_coor, y);
        chk({tag, ".xo"}, x_coor_obstacle, xo);
        chk({tag, ".go"}, 32'(game_over), 32'(go));
        chk({tag, ".pa"}, 32'(pause), 32'(pa));
        chk({tag, ".sc"}, 32'(score), 32'(sc));
    endtask

    initial begin
        vecs[0] = '{0, 0, 0, 320, 680, 0, 0, 0};
        vecs[1] = '{0, 0, 0, 320, 680, 0, 0, 0};
        vecs[2] = '{1, 0, 0, 314, 676, 0, 0, 0};
        vecs[3] = '{0, 0, 0, 308, 672, 0, 0, 0};
        vecs[4] = '{1, 0, 0, 302, 668, 0, 0, 0};
        vecs[5] = '{0, 1, 0, 302, 668, 0, 1, 0};
        vecs[6] = '{1, 0, 1, 302, 668, 0, 1, 0};
        vecs[7] = '{0, 1, 0, 302, 668, 0, 0, 0};
        vecs[8] = '{0, 0, 0, 296, 664, 0, 0, 0};

        repeat (3) @(negedge clk);
        chk_all("rst", 320, 680, 0, 0, 0);
        chk("rst.x", x_coor, 100);
        chk("rst.yo", y_coor_obstacle, 320);
        reset = 1'b1;
        frames(3);
        chk_all("idle", 320, 680, 0, 0, 0);

        for (int i = 0; i < 9; i++) begin
            if (vecs[i].jump || vecs[i].pse) press(vecs[i].jump, vecs[i].pse);
            collision_detected = vecs[i].coll;
            frame();
            collision_detected = 1'b0;
            chk_all($sformatf("v%0d", i), vecs[i].y, vecs[i].xo, vecs[i].go, vecs[i].pa, vecs[i].sc);
        end

        frames(16);
        chk_all("apex", 200, 600, 0, 0, 0);
        press(1, 0);
        frames(20);
        chk_all("land", 320, 520, 0, 0, 0);
        frames(129);
        chk_all("near", 320, 4, 0, 0, 0);
        frame();
        chk_all("clr1", 320, 680, 0, 0, 1);
        frames(680);
        chk_all("clr5", 320, 680, 0, 0, 5);
        frame();
        chk_all("spd5", 320, 675, 0, 0, 5);

        press(0, 1);
        collision_detected = 1'b1;
        frame();
        collision_detected = 1'b0;
        chk_all("over", 320, 675, 1, 0, 5);
        press(0, 1);
        frame();
        chk_all("ovp", 320, 675, 1, 0, 5);
        press(1, 0);
        frame();
        chk_all("rest", 320, 680, 0, 0, 0);
        frame();
        chk_all("rrun", 320, 676, 0, 0, 0);

        press(1, 0);
        frames(10);
        chk_all("mid", 260, 636, 0, 0, 0);
        @(posedge clk);
        #3 reset = 1'b0;
        #1 chk_all("arst", 320, 680, 0, 0, 0);
        @(negedge clk) reset = 1'b1;
        frame();
        chk_all("pidl", 320, 680, 0, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
